median_window_feeder: RTL and testbench

//  Upstream stage of the 3x3 median filter. Accepts a raster-scan pixel stream and

---
 rtl/median_pkg.sv | 17 +
 rtl/median_line_buffer.sv | 32 +++
 rtl/median_window_feeder.sv | 122 ++++++++++++
 tb/tb_median_window_feeder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared types for the 3x3 median filter front end:
// pixel type, feeder FSM states and window tap count.
package median_pkg;

  localparam int DEF_SIZE = 8;
  localparam int N_TAPS   = 9;

  typedef logic [DEF_SIZE-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    SEND,
    WAIT
  } feeder_state_t;

endpackage

// File: rtl/median_line_buffer.sv
// Two-line pixel store, WIDTH entries each, read-before-write.
// Ports: clk, addr, wr_en, din in; lb0 (prev line), lb1 (two back) out.
module median_line_buffer
  import median_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic [AW-1:0]   addr,
  input  logic            wr_en,
  input  logic [SIZE-1:0] din,
  output logic [SIZE-1:0] lb0,
  output logic [SIZE-1:0] lb1
);

  logic [SIZE-1:0] r_line0 [WIDTH];
  logic [SIZE-1:0] r_line1 [WIDTH];

  assign lb0 = r_line0[addr];
  assign lb1 = r_line1[addr];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_line1[addr] <= r_line0[addr];
      r_line0[addr] <= din;
    end
  end

endmodule

// File: rtl/median_window_feeder.sv
// Raster stream -> 3x3 window, bursts 9 taps to the median core.
// Ports: CLK, nRST, PIX_IN/VALID/READY, DI/DSI out, MED_DSO in, FRAME_DONE.
module median_window_feeder
  import median_pkg::*;
#(
  parameter int SIZE   = DEF_SIZE,
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [SIZE-1:0] PIX_IN,
  input  logic            PIX_VALID,
  output logic            PIX_READY,
  output logic [SIZE-1:0] DI,
  output logic            DSI,
  input  logic            MED_DSO,
  output logic            FRAME_DONE
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int KW = $clog2(N_TAPS);

  feeder_state_t   r_state;
  feeder_state_t   w_next;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [KW-1:0]   r_k;
  logic            r_last;
  logic            r_done;
  logic [SIZE-1:0] r_win [N_TAPS];

  logic            w_xfer;
  logic            w_col_end;
  logic            w_row_end;
  logic            w_emit;
  logic            w_frame_end;
  logic            w_k_end;
  logic [SIZE-1:0] w_lb0;
  logic [SIZE-1:0] w_lb1;
  logic [SIZE-1:0] w_new [3];

  median_line_buffer #(
    .SIZE  (SIZE),
    .WIDTH (WIDTH),
    .AW    (CW)
  ) u_lb (
    .clk   (CLK),
    .addr  (r_col),
    .wr_en (w_xfer),
    .din   (PIX_IN),
    .lb0   (w_lb0),
    .lb1   (w_lb1)
  );

  assign w_xfer      = (r_state == ACCEPT) & PIX_VALID;
  assign w_col_end   = r_col == CW'(WIDTH - 1);
  assign w_row_end   = r_row == RW'(HEIGHT - 1);
  assign w_emit      = (r_row >= RW'(2)) & (r_col >= CW'(2));
  assign w_frame_end = w_col_end & w_row_end;
  assign w_k_end     = r_k == KW'(N_TAPS - 1);

  // Incoming column, top to bottom.
  assign w_new[0] = w_lb1;
  assign w_new[1] = w_lb0;
  assign w_new[2] = PIX_IN;

  assign PIX_READY  = r_state == ACCEPT;
  assign DSI        = r_state == SEND;
  assign DI         = DSI ? r_win[r_k] : '0;
  assign FRAME_DONE = r_done;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = ACCEPT;
      ACCEPT:  if (w_xfer && w_emit) w_next = SEND;
      SEND:    if (w_k_end) w_next = WAIT;
      WAIT:    if (MED_DSO) w_next = ACCEPT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_k     <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < N_TAPS; i++)
        r_win[i] <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      if (w_xfer) begin
        for (int r = 0; r < 3; r++) begin
          r_win[3*r]   <= r_win[3*r+1];
          r_win[3*r+1] <= r_win[3*r+2];
          r_win[3*r+2] <= w_new[r];
        end
        r_last <= w_frame_end;
        if (w_col_end) begin
          r_col <= '0;
          r_row <= w_row_end ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (!w_emit && w_frame_end)
          r_done <= 1'b1;
      end
      if (r_state == SEND)
        r_k <= w_k_end ? '0 : r_k + 1'b1;
      // Frame completes only once the core finished the last window.
      if (r_state == WAIT && MED_DSO && r_last)
        r_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_median_window_feeder.sv
// Directed bench for median_window_feeder, 4x4 frames,
// with a median-core model answering 30 cycles after each burst.
module tb_median_window_feeder;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic [7:0] di;
  logic       dsi;
  logic       med_dso = 1'b0;
  logic       frame_done;

  always #5 clk = ~clk;

  median_window_feeder #(
    .SIZE   (8),
    .WIDTH  (W),
    .HEIGHT (H)
  ) dut (
    .CLK        (clk),
    .nRST       (nrst),
    .PIX_IN     (pix_in),
    .PIX_VALID  (pix_valid),
    .PIX_READY  (pix_ready),
    .DI         (di),
    .DSI        (dsi),
    .MED_DSO    (med_dso),
    .FRAME_DONE (frame_done)
  );

  typedef struct {
    string name;
    int    exp [9];
  } burst_t;

  burst_t     tbl [4];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] cap [$];
  int         dso_seen = 0;
  int         fd_cnt = 0;
  int         run = 0;
  bit         waiting = 0;
  bit         rdy_bad = 0;
  bit         want_rdy = 0;
  bit         abort = 0;
  logic       dsi_q = 1'b0;
  int         dso_cnt = 0;

  function automatic void chk(bit ok, string name, int act, int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endfunction

  // Median core model: MED_DSO one cycle, 30 cycles after DSI falls.
  always @(posedge clk) begin
    #1;
    med_dso = 1'b0;
    if (!nrst) begin
      dso_cnt = 0;
      dsi_q   = 1'b0;
    end else begin
      if (dsi_q && !dsi) begin
        dso_cnt = 30;
      end else if (dso_cnt > 0) begin
        dso_cnt--;
        if (dso_cnt == 0) med_dso = 1'b1;
      end
      dsi_q = dsi;
    end
  end

  // Burst capture plus handshake checks.
  always @(negedge clk) begin
    if (!nrst) begin
      run      = 0;
      waiting  = 0;
      rdy_bad  = 0;
      want_rdy = 0;
    end else begin
      if (want_rdy) begin
        chk(pix_ready === 1'b1, "ready_after_dso", int'(pix_ready), 1);
        want_rdy = 0;
      end
      if (dsi) begin
        cap.push_back(di);
        run++;
        waiting = 1;
        if (pix_ready !== 1'b0) rdy_bad = 1;
      end else begin
        if (run > 0) begin
          chk(run == 9, "dsi_len", run, 9);
          run = 0;
        end
        if (waiting && pix_ready !== 1'b0) rdy_bad = 1;
      end
      if (med_dso) begin
        dso_seen++;
        if (waiting) begin
          chk(!rdy_bad, "ready_low", int'(rdy_bad), 0);
          want_rdy = 1;
        end
        waiting = 0;
        rdy_bad = 0;
      end
      if (frame_done) begin
        fd_cnt++;
        chk(dso_seen > 0 && dso_seen % 4 == 0, "fd_timing", dso_seen, 4);
      end
    end
  end

  task automatic drive_frame(input int off, input bit gaps);
    int i = 0;
    bit took = 0;
    int guard = 0;
    while (i < 16 && !abort && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (took) i++;
      took = 0;
      if (i < 16 && !abort) begin
        pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        pix_in    = 8'(i + off);
        took      = pix_valid && pix_ready;
      end else begin
        pix_valid = 1'b0;
      end
    end
    pix_valid = 1'b0;
    if (!abort) chk(i == 16, "drive_done", i, 16);
  endtask

  task automatic wait_dso(input int n, input string name);
    int c = 0;
    while (dso_seen < n && c < 5000) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk(dso_seen >= n, name, dso_seen, n);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic cmp_bursts(input int base, input int off, input string name);
    for (int b = 0; b < 4; b++) begin
      int idx = -1;
      int a = 0;
      int e = 0;
      for (int j = 0; j < 9; j++) begin
        int p;
        int got;
        int want;
        p    = (base + b) * 9 + j;
        got  = p < cap.size() ? int'(cap[p]) : -1;
        want = tbl[b].exp[j] + off;
        if (got != want && idx < 0) begin
          idx = j;
          a   = got;
          e   = want;
        end
      end
      chk(idx < 0, $sformatf("%s_%s", name, tbl[b].name), a, e);
    end
  endtask

  task automatic clear_run();
    cap.delete();
    dso_seen = 0;
    fd_cnt   = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got 0 want 1");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    tbl[0].name = "b0";
    tbl[0].exp  = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    tbl[1].name = "b1";
    tbl[1].exp  = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    tbl[2].name = "b2";
    tbl[2].exp  = '{4, 5, 6, 8, 9, 10, 12, 13, 14};
    tbl[3].name = "b3";
    tbl[3].exp  = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

    // Reset with VALID held high.
    #2;
    nrst      = 1'b0;
    pix_valid = 1'b1;
    pix_in    = 8'hAA;
    repeat (3) @(negedge clk);
    chk(pix_ready === 1'b0, "rst_ready", int'(pix_ready), 0);
    chk(dsi === 1'b0, "rst_dsi", int'(dsi), 0);
    chk(di === 8'h00, "rst_di", int'(di), 0);
    chk(frame_done === 1'b0, "rst_fd", int'(frame_done), 0);
    nrst      = 1'b1;
    pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk(pix_ready === 1'b1, "rel_ready", int'(pix_ready), 1);

    // Continuous stream.
    clear_run();
    drive_frame(0, 1'b0);
    wait_dso(4, "t2_dso");
    chk(cap.size() == 36, "t2_count", cap.size(), 36);
    cmp_bursts(0, 0, "t2");
    chk(fd_cnt == 1, "t2_fd", fd_cnt, 1);

    // Random VALID gaps.
    clear_run();
    drive_frame(0, 1'b1);
    wait_dso(4, "t4_dso");
    chk(cap.size() == 36, "t4_count", cap.size(), 36);
    cmp_bursts(0, 0, "t4");
    chk(fd_cnt == 1, "t4_fd", fd_cnt, 1);

    // Two frames back-to-back.
    clear_run();
    drive_frame(0, 1'b0);
    drive_frame(100, 1'b0);
    wait_dso(8, "t5_dso");
    chk(cap.size() == 72, "t5_count", cap.size(), 72);
    cmp_bursts(0, 0, "t5f1");
    cmp_bursts(4, 100, "t5f2");
    chk(fd_cnt == 2, "t5_fd", fd_cnt, 2);

    // Reset in the middle of the second burst.
    clear_run();
    fork
      drive_frame(0, 1'b0);
    join_none
    c = 0;
    while (cap.size() < 14 && c < 3000) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk(cap.size() == 14, "t6_reach", cap.size(), 14);
    chk(int'(di) == tbl[1].exp[4], "t6_k4_di", int'(di), tbl[1].exp[4]);
    abort = 1;
    #1;
    nrst = 1'b0;
    #1;
    chk(dsi === 1'b0, "t6_dsi_drop", int'(dsi), 0);
    chk(di === 8'h00, "t6_di_drop", int'(di), 0);
    repeat (3) @(negedge clk);
    clear_run();
    nrst  = 1'b1;
    abort = 0;
    drive_frame(0, 1'b0);
    wait_dso(4, "t6_dso");
    chk(cap.size() == 36, "t6_count", cap.size(), 36);
    cmp_bursts(0, 0, "t6");
    chk(fd_cnt == 1, "t6_fd", fd_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
